// File: rtl/hist_equalizer_if.sv
// rtl/hist_equalizer_if.sv - pixel input/output stream handshake bundle for hist_equalizer
interface hist_equalizer_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    // Pixel source / sink side (testbench or surrounding pipeline)
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );

    // Equalizer side
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );
endinterface

// File: rtl/hist_equalizer.sv
// rtl/hist_equalizer.sv - two-pass histogram equalizer; optional HIST_EQ_BYPASS_EN adds a bypass input
module hist_equalizer #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 320
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
`ifdef HIST_EQ_BYPASS_EN
    input  logic bypass,
`endif
    output logic busy,
    output logic done,
    hist_equalizer_if.slave px
);
    localparam int          NPIX    = WIDTH * HEIGHT;
    localparam logic [16:0] NPIX_W  = 17'(NPIX);
    localparam logic [16:0] NPIX_M1 = 17'(NPIX - 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_HIST, S_CDF, S_LUT, S_MAP, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [16:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic [16:0] acc_q, acc_d, cdf_min_q, cdf_min_d;
    logic        div_run_q, div_run_d;
    logic [4:0]  div_cnt_q, div_cnt_d;
    logic [16:0] rem_q, rem_d;
    logic [24:0] quo_q, quo_d;
    logic        wr_en_q, wr_en_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [16:0] wr_val_q, wr_val_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic        byp_q, byp_d;

    // Bins hold the histogram, then the cdf in place; neither array is reset
    logic [16:0] hist_mem [256];
    logic [7:0]  lut_mem  [256];
    logic        lut_we;
    logic [7:0]  lut_wdata;
    logic        lut_adv;
    logic        in_ready_c;

    // Bin writes are registered one cycle; reads forward the pending write so
    // back-to-back hits on one bin (and the cdf/lut hand-offs) see fresh data
    logic [7:0]  rd_addr;
    logic [16:0] rd_val;
    logic [16:0] cdf_sum;
    logic [16:0] den;
    logic [17:0] rem_sh;
    logic        rem_ge;
    logic [16:0] rem_nx;
    logic [24:0] quo_nx;
    logic [7:0]  quo_clamp;

    assign rd_addr   = (state_q == S_HIST) ? px.in_data : idx_q;
    assign rd_val    = (wr_en_q && wr_addr_q == rd_addr) ? wr_val_q : hist_mem[rd_addr];
    assign cdf_sum   = acc_q + rd_val;
    assign den       = NPIX_W - cdf_min_q;
    assign rem_sh    = {rem_q, quo_q[24]};
    assign rem_ge    = rem_sh >= {1'b0, den};
    assign rem_nx    = rem_ge ? 17'(rem_sh - {1'b0, den}) : rem_sh[16:0];
    assign quo_nx    = {quo_q[23:0], rem_ge};
    assign quo_clamp = (|quo_nx[24:8]) ? 8'd255 : quo_nx[7:0];

    // Next-state and datapath control for the whole frame sequence
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        acc_d       = acc_q;
        cdf_min_d   = cdf_min_q;
        div_run_d   = div_run_q;
        div_cnt_d   = div_cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_val_d    = wr_val_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        byp_d       = byp_q;
        lut_we      = 1'b0;
        lut_wdata   = 8'd0;
        lut_adv     = 1'b0;
        in_ready_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef HIST_EQ_BYPASS_EN
                    byp_d = bypass;
`else
                    byp_d = 1'b0;
`endif
                    in_cnt_d    = '0;
                    out_cnt_d   = '0;
                    cdf_min_d   = '0;
                    idx_d       = '0;
                    div_run_d   = 1'b0;
                    out_valid_d = 1'b0;
                    state_d     = byp_d ? S_MAP : S_CLEAR;
                end
            end
            S_CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = idx_q;
                wr_val_d  = '0;
                idx_d     = idx_q + 8'd1;
                if (idx_q == 8'd255) state_d = S_HIST;
            end
            S_HIST: begin
                in_ready_c = 1'b1;
                if (px.in_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = px.in_data;
                    wr_val_d  = rd_val + 17'd1;
                    in_cnt_d  = in_cnt_q + 17'd1;
                    if (in_cnt_q == NPIX_M1) begin
                        in_cnt_d = '0;
                        acc_d    = '0;
                        state_d  = S_CDF;
                    end
                end
            end
            S_CDF: begin
                wr_en_d   = 1'b1;
                wr_addr_d = idx_q;
                wr_val_d  = cdf_sum;
                acc_d     = cdf_sum;
                if (cdf_min_q == '0 && cdf_sum != '0) cdf_min_d = cdf_sum;
                idx_d = idx_q + 8'd1;
                if (idx_q == 8'd255) state_d = S_LUT;
            end
            S_LUT: begin
                if (!div_run_q) begin
                    if (cdf_min_q == NPIX_W) begin
                        lut_we    = 1'b1;
                        lut_wdata = idx_q;
                        lut_adv   = 1'b1;
                    end else if (rd_val < cdf_min_q) begin
                        lut_we  = 1'b1;
                        lut_adv = 1'b1;
                    end else begin
                        rem_d     = '0;
                        quo_d     = 25'(rd_val - cdf_min_q) * 25'd255;
                        div_cnt_d = 5'd24;
                        div_run_d = 1'b1;
                    end
                end else begin
                    rem_d     = rem_nx;
                    quo_d     = quo_nx;
                    div_cnt_d = div_cnt_q - 5'd1;
                    if (div_cnt_q == 5'd0) begin
                        lut_we    = 1'b1;
                        lut_wdata = quo_clamp;
                        lut_adv   = 1'b1;
                        div_run_d = 1'b0;
                    end
                end
                if (lut_adv) begin
                    idx_d = idx_q + 8'd1;
                    if (idx_q == 8'd255) state_d = S_MAP;
                end
            end
            S_MAP: begin
                in_ready_c = (!out_valid_q || px.out_ready) && (in_cnt_q != NPIX_W);
                if (out_valid_q && px.out_ready) out_valid_d = 1'b0;
                if (px.in_valid && in_ready_c) begin
                    out_valid_d = 1'b1;
                    out_data_d  = byp_q ? {24'd0, px.in_data} : {24'd0, lut_mem[px.in_data]};
                    in_cnt_d    = in_cnt_q + 17'd1;
                end
                if (out_valid_q && px.out_ready) begin
                    out_cnt_d = out_cnt_q + 17'd1;
                    if (out_cnt_q == NPIX_M1) begin
                        out_valid_d = 1'b0;
                        state_d     = S_DONE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state; reset returns everything to an idle, cleared frame
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            acc_q       <= '0;
            cdf_min_q   <= '0;
            div_run_q   <= 1'b0;
            div_cnt_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_val_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            byp_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            acc_q       <= acc_d;
            cdf_min_q   <= cdf_min_d;
            div_run_q   <= div_run_d;
            div_cnt_q   <= div_cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_val_q    <= wr_val_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            byp_q       <= byp_d;
        end
    end

    // Histogram/cdf and lookup-table arrays, rewritten every frame
    always_ff @(posedge clock) begin
        if (wr_en_q) hist_mem[wr_addr_q] <= wr_val_q;
        if (lut_we)  lut_mem[idx_q]      <= lut_wdata;
    end

    assign px.in_ready  = in_ready_c;
    assign px.out_valid = out_valid_q;
    assign px.out_data  = out_data_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
endmodule

// File: tb/tb_hist_equalizer.sv
// tb/tb_hist_equalizer.sv - directed table-driven bench for hist_equalizer
module tb_hist_equalizer;
    localparam int W    = 16;
    localparam int H    = 16;
    localparam int NPIX = W * H;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic bypass = 1'b0;
    logic busy, done;

    hist_equalizer_if px();

    hist_equalizer #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
`ifdef HIST_EQ_BYPASS_EN
        .bypass(bypass),
`endif
        .busy  (busy),
        .done  (done),
        .px    (px)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit ramp;
        bit stall;
        int lv0, lv1, lv2;
        int c0, c1;
        int e0, e1, e2;
    } rec_t;

    rec_t recs [6];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pix_of(input rec_t r, input int i);
        if (r.ramp) return i % 256;
        if (i < r.c0) return r.lv0;
        if (i < r.c0 + r.c1) return r.lv1;
        return r.lv2;
    endfunction

    function automatic int exp_of(input rec_t r, input int i);
        if (r.ramp) return i % 256;
        if (i < r.c0) return r.e0;
        if (i < r.c0 + r.c1) return r.e1;
        return r.e2;
    endfunction

    // n_pass: 2 for equalize, 1 for bypass; rst_at>0 aborts with reset after that many accepts
    task automatic run_frame(input rec_t r, input int n_pass, input int rst_at, input string tag);
        int in_idx = 0, out_idx = 0, cyc = 0, done_cnt = 0, tail = 0;
        bit held = 0, prev_acc = 0;
        logic [31:0] held_data = 0;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        check({tag, " busy_after_start"}, {31'd0, busy}, 32'd1);
        if (n_pass == 1) check({tag, " map_next_cycle"}, {31'd0, px.in_ready}, 32'd1);
        while (cyc < 30000 && tail < 4) begin
            @(negedge clock);
            cyc++;
            if (done) done_cnt++;
            if (held) begin
                check({tag, " stall_valid"}, {31'd0, px.out_valid}, 32'd1);
                check({tag, " stall_data"}, px.out_data, held_data);
            end
            if (prev_acc) check({tag, " map_latency"}, {31'd0, px.out_valid}, 32'd1);
            if (out_idx >= NPIX) tail++;
            px.out_ready = r.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            px.in_valid  = (in_idx < n_pass * NPIX) && (!r.stall || (cyc % 5 != 2));
            px.in_data   = 8'(pix_of(r, in_idx % NPIX));
            start        = (cyc == 20);
            #1;
            if (px.out_valid && px.out_ready) begin
                check({tag, " out_data"}, px.out_data, 32'(exp_of(r, out_idx % NPIX)));
                out_idx++;
            end
            held      = px.out_valid && !px.out_ready;
            held_data = px.out_data;
            prev_acc  = px.in_valid && px.in_ready && (in_idx >= (n_pass - 1) * NPIX);
            if (px.in_valid && px.in_ready) in_idx++;
            if (rst_at > 0 && in_idx == rst_at) begin
                @(posedge clock); #2;
                reset = 1'b0;
                #1;
                check({tag, " rst_in_ready"},  {31'd0, px.in_ready},  32'd0);
                check({tag, " rst_out_valid"}, {31'd0, px.out_valid}, 32'd0);
                check({tag, " rst_out_data"},  px.out_data,           32'd0);
                check({tag, " rst_busy"},      {31'd0, busy},         32'd0);
                check({tag, " rst_done"},      {31'd0, done},         32'd0);
                @(negedge clock);
                px.in_valid = 1'b0;
                start = 1'b0;
                reset = 1'b1;
                @(negedge clock);
                return;
            end
        end
        px.in_valid = 1'b0;
        start = 1'b0;
        check({tag, " out_count"}, 32'(out_idx), 32'(NPIX));
        check({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, " idle_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        px.in_valid  = 1'b0;
        px.in_data   = 8'd0;
        px.out_ready = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_in_ready",  {31'd0, px.in_ready},  32'd0);
        check("reset_out_valid", {31'd0, px.out_valid}, 32'd0);
        check("reset_out_data",  px.out_data,           32'd0);
        check("reset_busy",      {31'd0, busy},         32'd0);
        check("reset_done",      {31'd0, done},         32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_in_ready", {31'd0, px.in_ready}, 32'd0);

        //          ramp stall lv0  lv1  lv2  c0   c1   e0 e1   e2
        recs[0] = '{1'b0, 1'b0, 100, 0,   0,   256, 0,   100, 0,   0};
        recs[1] = '{1'b0, 1'b0, 0,   255, 0,   128, 128, 0,   255, 0};
        recs[2] = '{1'b1, 1'b0, 0,   0,   0,   0,   0,   0,   0,   0};
        recs[3] = '{1'b1, 1'b1, 0,   0,   0,   0,   0,   0,   0,   0};
        recs[4] = '{1'b0, 1'b0, 50,  60,  70,  128, 64,  0,   127, 255};
        recs[5] = '{1'b0, 1'b1, 1,   2,   3,   64,  64,  0,   85,  255};

        for (int i = 0; i < 6; i++) begin
            run_frame(recs[i], 2, 0, $sformatf("rec%0d", i));
        end

        run_frame(recs[2], 2, 100, "rst_hist");
        run_frame(recs[2], 2, NPIX + 100, "rst_map");
        run_frame(recs[2], 2, 0, "ramp_after_rst");

`ifdef HIST_EQ_BYPASS_EN
        bypass = 1'b1;
        run_frame(recs[2], 1, 0, "bypass");
        bypass = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
